// File: rtl/sbox_share_sched.sv
// Time-shares NUM_SBOX SubBytes lanes between a multi-beat 128-bit state job and
// single-cycle 32-bit key-word requests, with key priority and a one-beat steal limit.
`timescale 1ns/1ps
module sbox_share_sched #(
    parameter int NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_data,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out_data,
    input  logic         kw_valid,
    output logic         kw_ready,
    input  logic [31:0]  kw_data,
    output logic         kw_out_valid,
    input  logic         kw_out_ready,
    output logic [31:0]  kw_out_data,
    output logic         busy
);

    localparam int BEATS = 16 / NUM_SBOX;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[x];
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} st_state_t;

    st_state_t        state;
    logic [CNT_W-1:0] beat;
    logic [127:0]     work;
    logic [127:0]     work_next;
    logic             steal_flag;
    logic             key_acc;
    logic             st_acc;
    logic             beat_go;

    logic [7:0] beat_bytes [BEATS][NUM_SBOX];
    logic [7:0] st_lane    [NUM_SBOX];
    logic [7:0] lane_in    [NUM_SBOX];
    logic [7:0] lane_out   [NUM_SBOX];

    assign kw_ready     = (!kw_out_valid || kw_out_ready) && !steal_flag;
    assign key_acc      = kw_valid && kw_ready;
    assign st_ready     = (state == S_IDLE);
    assign st_acc       = st_valid && st_ready;
    // A key accept during a run cycle owns the lanes, so the whole beat stalls.
    assign beat_go      = (state == S_RUN) && !key_acc;
    assign st_out_valid = (state == S_DONE);
    assign st_out_data  = work;
    assign busy         = (state != S_IDLE) || kw_out_valid;

    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        for (genvar i = 0; i < NUM_SBOX; i++) begin : g_byte
            assign beat_bytes[b][i] = work[127 - 8*(b*NUM_SBOX + i) -: 8];
        end
    end

    always_comb begin
        st_lane = beat_bytes[0];
        for (int b = 1; b < BEATS; b++) begin
            if (beat == CNT_W'(b)) st_lane = beat_bytes[b];
        end
    end

    for (genvar i = 0; i < NUM_SBOX; i++) begin : g_lane
        if (i < 4) begin : g_shared
            assign lane_in[i] = key_acc ? kw_data[31 - 8*i -: 8] : st_lane[i];
        end else begin : g_state_only
            assign lane_in[i] = st_lane[i];
        end
        assign lane_out[i] = sbox(lane_in[i]);
    end

    for (genvar j = 0; j < 16; j++) begin : g_wb
        localparam int JB = j / NUM_SBOX;
        localparam int JL = j % NUM_SBOX;
        assign work_next[127 - 8*j -: 8] = (beat_go && beat == CNT_W'(JB)) ?
                                           lane_out[JL] : work[127 - 8*j -: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            beat         <= '0;
            steal_flag   <= 1'b0;
            work         <= '0;
            kw_out_valid <= 1'b0;
            kw_out_data  <= '0;
        end else begin
            // Only a steal out of a running job blocks the next key word.
            steal_flag <= key_acc && (state == S_RUN);

            if (key_acc) begin
                kw_out_valid <= 1'b1;
                kw_out_data  <= {lane_out[0], lane_out[1], lane_out[2], lane_out[3]};
            end else if (kw_out_ready) begin
                kw_out_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (st_acc) begin
                        work  <= st_data;
                        beat  <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (beat_go) begin
                        work <= work_next;
                        if (beat == LAST_BEAT) state <= S_DONE;
                        else                   beat  <= beat + 1'b1;
                    end
                end
                S_DONE: begin
                    if (st_out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_share_sched.sv
// Bench for sbox_share_sched: a 4-lane and a 16-lane instance, with a GF(2^8)
// inverse/affine reference model feeding per-path expected-result queues.
`timescale 1ns/1ps
module tb_sbox_share_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         st_valid, st_ready, st_out_valid, st_out_ready;
    logic [127:0] st_data, st_out_data;
    logic         kw_valid, kw_ready, kw_out_valid, kw_out_ready, busy;
    logic [31:0]  kw_data, kw_out_data;

    logic         w_st_valid, w_st_ready, w_st_out_valid, w_st_out_ready;
    logic [127:0] w_st_data, w_st_out_data;
    logic         w_kw_valid, w_kw_ready, w_kw_out_valid, w_kw_out_ready, w_busy;
    logic [31:0]  w_kw_data, w_kw_out_data;

    sbox_share_sched #(.NUM_SBOX(4)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .st_out_valid(st_out_valid), .st_out_ready(st_out_ready), .st_out_data(st_out_data),
        .kw_valid(kw_valid), .kw_ready(kw_ready), .kw_data(kw_data),
        .kw_out_valid(kw_out_valid), .kw_out_ready(kw_out_ready), .kw_out_data(kw_out_data),
        .busy(busy)
    );

    sbox_share_sched #(.NUM_SBOX(16)) dut_w (
        .clk(clk), .rst(rst),
        .st_valid(w_st_valid), .st_ready(w_st_ready), .st_data(w_st_data),
        .st_out_valid(w_st_out_valid), .st_out_ready(w_st_out_ready), .st_out_data(w_st_out_data),
        .kw_valid(w_kw_valid), .kw_ready(w_kw_ready), .kw_data(w_kw_data),
        .kw_out_valid(w_kw_out_valid), .kw_out_ready(w_kw_out_ready), .kw_out_data(w_kw_out_data),
        .busy(w_busy)
    );

    localparam logic [127:0] T1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] R1 = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] T3 = 128'h3243f6a8885a308d313198a2e0370734;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [127:0] st_q[$];
    logic [31:0]  kw_q[$];
    logic [127:0] w_st_q[$];
    logic [31:0]  w_kw_q[$];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sb(input logic [7:0] v);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (v != 8'h00 && gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) r[127 - 8*j -: 8] = ref_sb(s[127 - 8*j -: 8]);
        return r;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] w);
        return {ref_sb(w[31:24]), ref_sb(w[23:16]), ref_sb(w[15:8]), ref_sb(w[7:0])};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard: push on accept, pop on output transfer (sampled mid-cycle).
    initial begin
        logic [127:0] e128;
        logic [31:0]  e32;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (st_out_valid && st_out_ready) begin
                    n_cmp++;
                    if (st_q.size() == 0) begin
                        n_bad++; $display("FAIL sb_state4 unexpected output %h", st_out_data);
                    end else begin
                        e128 = st_q.pop_front();
                        if (st_out_data !== e128) begin
                            n_bad++; $display("FAIL sb_state4 got %h want %h", st_out_data, e128);
                        end
                    end
                end
                if (kw_out_valid && kw_out_ready) begin
                    n_cmp++;
                    if (kw_q.size() == 0) begin
                        n_bad++; $display("FAIL sb_key4 unexpected output %h", kw_out_data);
                    end else begin
                        e32 = kw_q.pop_front();
                        if (kw_out_data !== e32) begin
                            n_bad++; $display("FAIL sb_key4 got %h want %h", kw_out_data, e32);
                        end
                    end
                end
                if (w_st_out_valid && w_st_out_ready) begin
                    n_cmp++;
                    if (w_st_q.size() == 0) begin
                        n_bad++; $display("FAIL sb_state16 unexpected output %h", w_st_out_data);
                    end else begin
                        e128 = w_st_q.pop_front();
                        if (w_st_out_data !== e128) begin
                            n_bad++; $display("FAIL sb_state16 got %h want %h", w_st_out_data, e128);
                        end
                    end
                end
                if (w_kw_out_valid && w_kw_out_ready) begin
                    n_cmp++;
                    if (w_kw_q.size() == 0) begin
                        n_bad++; $display("FAIL sb_key16 unexpected output %h", w_kw_out_data);
                    end else begin
                        e32 = w_kw_q.pop_front();
                        if (w_kw_out_data !== e32) begin
                            n_bad++; $display("FAIL sb_key16 got %h want %h", w_kw_out_data, e32);
                        end
                    end
                end
                if (st_valid && st_ready)     st_q.push_back(ref_state(st_data));
                if (kw_valid && kw_ready)     kw_q.push_back(ref_word(kw_data));
                if (w_st_valid && w_st_ready) w_st_q.push_back(ref_state(w_st_data));
                if (w_kw_valid && w_kw_ready) w_kw_q.push_back(ref_word(w_kw_data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Waits for st_out_valid; lat is cycles since the accept edge, -1 on timeout.
    task automatic wait_out(input int acc, input bit wide, output int lat);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((wide ? w_st_out_valid : st_out_valid) === 1'b1) begin
                lat = cyc - acc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        st_valid = 0; st_data = '0; st_out_ready = 0; kw_valid = 0; kw_data = '0; kw_out_ready = 0;
        w_st_valid = 0; w_st_data = '0; w_st_out_ready = 0;
        w_kw_valid = 0; w_kw_data = '0; w_kw_out_ready = 0;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (st_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_st_out_valid got %b want 0", st_out_valid); end
        n_cmp++; if (kw_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_kw_out_valid got %b want 0", kw_out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (st_out_data !== 128'h0) begin n_bad++; $display("FAIL rst_st_out_data got %h want 0", st_out_data); end
        n_cmp++; if (kw_out_data !== 32'h0) begin n_bad++; $display("FAIL rst_kw_out_data got %h want 0", kw_out_data); end
        n_cmp++; if (st_ready !== 1'b1) begin n_bad++; $display("FAIL rst_st_ready got %b want 1", st_ready); end
        n_cmp++; if (w_busy !== 1'b0) begin n_bad++; $display("FAIL rst_w_busy got %b want 0", w_busy); end
        tick();
        tick();
        rst = 1'b0;
        st_out_ready = 1; kw_out_ready = 1; w_st_out_ready = 1; w_kw_out_ready = 1;
        mid();
        n_cmp++; if (kw_ready !== 1'b1) begin n_bad++; $display("FAIL rst_kw_ready got %b want 1", kw_ready); end
    endtask

    task automatic test_state_basic();
        int acc, lat;
        tick();
        st_data = T1; st_valid = 1;
        mid();
        n_cmp++; if (st_ready !== 1'b1) begin n_bad++; $display("FAIL basic_st_ready got %b want 1", st_ready); end
        tick();
        st_valid = 0; acc = cyc;
        wait_out(acc, 1'b0, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL basic_latency got %0d want 4", lat); end
        n_cmp++; if (st_out_data !== R1) begin n_bad++; $display("FAIL basic_data got %h want %h", st_out_data, R1); end
        n_cmp++; if (st_ready !== 1'b0) begin n_bad++; $display("FAIL basic_st_ready_done got %b want 0", st_ready); end
        tick();
        mid();
        n_cmp++; if (st_out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_drop got %b want 0", st_out_valid); end
        n_cmp++; if (st_ready !== 1'b1) begin n_bad++; $display("FAIL basic_st_ready_back got %b want 1", st_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy got %b want 0", busy); end
    endtask

    task automatic test_key_idle();
        tick();
        kw_data = 32'hcf4f3c09; kw_valid = 1;
        mid();
        n_cmp++; if (kw_ready !== 1'b1) begin n_bad++; $display("FAIL key_ready got %b want 1", kw_ready); end
        tick();
        kw_data = 32'h00000000;
        mid();
        n_cmp++; if (kw_out_valid !== 1'b1) begin n_bad++; $display("FAIL key_valid got %b want 1", kw_out_valid); end
        n_cmp++; if (kw_out_data !== 32'h8a84eb01) begin n_bad++; $display("FAIL key_cf4f got %h want 8a84eb01", kw_out_data); end
        tick();
        kw_data = 32'hffffffff;
        mid();
        n_cmp++; if (kw_out_data !== 32'h63636363) begin n_bad++; $display("FAIL key_zero got %h want 63636363", kw_out_data); end
        tick();
        kw_valid = 0;
        mid();
        n_cmp++; if (kw_out_data !== 32'h16161616) begin n_bad++; $display("FAIL key_ones got %h want 16161616", kw_out_data); end
        n_cmp++; if (kw_out_valid !== 1'b1) begin n_bad++; $display("FAIL key_b2b_valid got %b want 1", kw_out_valid); end
        tick();
        mid();
        n_cmp++; if (kw_out_valid !== 1'b0) begin n_bad++; $display("FAIL key_valid_drop got %b want 0", kw_out_valid); end
    endtask

    task automatic test_steal();
        int acc, lat;
        tick();
        st_data = T1; st_valid = 1;
        tick();
        st_valid = 0; acc = cyc;
        tick();
        kw_data = 32'h01234567; kw_valid = 1;
        mid();
        n_cmp++; if (kw_ready !== 1'b1) begin n_bad++; $display("FAIL steal_first_ready got %b want 1", kw_ready); end
        tick();
        kw_data = 32'h89abcdef;
        mid();
        n_cmp++; if (kw_ready !== 1'b0) begin n_bad++; $display("FAIL steal_blocked_ready got %b want 0", kw_ready); end
        n_cmp++; if (kw_out_data !== ref_word(32'h01234567)) begin n_bad++; $display("FAIL steal_word_a got %h want %h", kw_out_data, ref_word(32'h01234567)); end
        tick();
        mid();
        n_cmp++; if (kw_ready !== 1'b1) begin n_bad++; $display("FAIL steal_second_ready got %b want 1", kw_ready); end
        tick();
        kw_valid = 0;
        wait_out(acc, 1'b0, lat);
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL steal_latency got %0d want 6", lat); end
        n_cmp++; if (st_out_data !== R1) begin n_bad++; $display("FAIL steal_data got %h want %h", st_out_data, R1); end
        tick();
    endtask

    task automatic test_backpressure();
        int acc, lat;
        logic [127:0] t2, held;
        t2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        st_out_ready = 0;
        tick();
        st_data = t2; st_valid = 1;
        tick();
        st_valid = 0; acc = cyc;
        wait_out(acc, 1'b0, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL bp_latency got %0d want 4", lat); end
        held = st_out_data;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0) begin kw_data = 32'h5a3c96e1; kw_valid = 1; end
            if (k == 1) kw_valid = 0;
            if (k == 2) st_out_ready = 1;
            mid();
            n_cmp++; if (st_out_valid !== 1'b1 || st_out_data !== held) begin n_bad++; $display("FAIL bp_hold%0d got %b/%h want 1/%h", k, st_out_valid, st_out_data, held); end
            n_cmp++; if (st_ready !== 1'b0) begin n_bad++; $display("FAIL bp_st_ready%0d got %b want 0", k, st_ready); end
            if (k == 1) begin
                n_cmp++; if (kw_out_valid !== 1'b1 || kw_out_data !== ref_word(32'h5a3c96e1)) begin n_bad++; $display("FAIL bp_key got %b/%h want 1/%h", kw_out_valid, kw_out_data, ref_word(32'h5a3c96e1)); end
            end
        end
        tick();
        mid();
        n_cmp++; if (st_out_valid !== 1'b0 || st_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got valid %b ready %b want 0/1", st_out_valid, st_ready); end
    endtask

    task automatic test_reset_mid();
        int acc, lat;
        tick();
        st_data = T1; st_valid = 1; kw_data = 32'hdeadbeef; kw_valid = 1; kw_out_ready = 0;
        tick();
        st_valid = 0; kw_valid = 0;
        tick();
        tick();
        n_cmp++; if (kw_out_valid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL rmid_pre got kwv %b busy %b want 1/1", kw_out_valid, busy); end
        #2 rst = 1'b1;
        #1;
        st_q.delete(); kw_q.delete();
        n_cmp++; if (st_out_valid !== 1'b0 || kw_out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rmid_ctrl got %b%b%b want 000", st_out_valid, kw_out_valid, busy); end
        n_cmp++; if (st_out_data !== 128'h0 || kw_out_data !== 32'h0) begin n_bad++; $display("FAIL rmid_data got %h/%h want 0/0", st_out_data, kw_out_data); end
        tick();
        rst = 1'b0; kw_out_ready = 1;
        mid();
        n_cmp++; if (st_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_st_ready got %b want 1", st_ready); end
        tick();
        st_data = T1; st_valid = 1;
        tick();
        st_valid = 0; acc = cyc;
        wait_out(acc, 1'b0, lat);
        n_cmp++; if (lat !== 4 || st_out_data !== R1) begin n_bad++; $display("FAIL rmid_fresh got lat %0d data %h want 4/%h", lat, st_out_data, R1); end
        tick();
    endtask

    task automatic test_wide();
        int acc, lat;
        tick();
        w_st_data = T1; w_st_valid = 1;
        tick();
        w_st_valid = 0; acc = cyc;
        wait_out(acc, 1'b1, lat);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wide_latency got %0d want 1", lat); end
        n_cmp++; if (w_st_out_data !== R1) begin n_bad++; $display("FAIL wide_data got %h want %h", w_st_out_data, R1); end
        tick();
        tick();
        w_st_data = T3; w_st_valid = 1;
        tick();
        w_st_valid = 0; acc = cyc;
        w_kw_data = 32'h2b7e1516; w_kw_valid = 1;
        tick();
        w_kw_valid = 0;
        mid();
        n_cmp++; if (w_kw_out_valid !== 1'b1 || w_kw_out_data !== ref_word(32'h2b7e1516)) begin n_bad++; $display("FAIL wide_key got %b/%h want 1/%h", w_kw_out_valid, w_kw_out_data, ref_word(32'h2b7e1516)); end
        wait_out(acc, 1'b1, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wide_steal_latency got %0d want 2", lat); end
        n_cmp++; if (w_st_out_data !== ref_state(T3)) begin n_bad++; $display("FAIL wide_steal_data got %h want %h", w_st_out_data, ref_state(T3)); end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_state_basic();
        test_key_idle();
        test_steal();
        test_backpressure();
        test_reset_mid();
        test_wide();
        mid();
        n_cmp++; if (st_q.size() + kw_q.size() + w_st_q.size() + w_kw_q.size() != 0) begin
            n_bad++; $display("FAIL drain pending %0d/%0d/%0d/%0d want all 0", st_q.size(), kw_q.size(), w_st_q.size(), w_kw_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sbox_share_sched.md
Name: sbox_share_sched

Overview:
- Time-shares a bank of NUM_SBOX combinational SubBytes instances between two requesters.
  - Round datapath: 128-bit state, processed over several beats.
  - Key expansion: 32-bit SubWord, processed in a single cycle.
- Key requests have priority and may steal one beat from an in-flight state job.
- An anti-starvation rule guarantees the state job progresses.
- Sits between the AES round controller / key scheduler and the S-box bank. Replaces per-requester S-box copies.

Parameters:
- NUM_SBOX, 4, S-box lanes instantiated; legal values 4, 8, 16.
- BEATS, 16/NUM_SBOX, derived localparam: state beats per job.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_valid  in  1  state job request.
- st_ready  out  1  state job accepted when st_valid&st_ready.
- st_data  in  128  input state; byte j = st_data[127-8j -: 8].
- st_out_valid  out  1  substituted state available.
- st_out_ready  in  1  consumer accepts st_out_data.
- st_out_data  out  128  substituted state, same byte order.
- kw_valid  in  1  key word request.
- kw_ready  out  1  key word accepted when kw_valid&kw_ready.
- kw_data  in  32  key word; byte j = kw_data[31-8j -: 8].
- kw_out_valid  out  1  SubWord result available.
- kw_out_ready  in  1  consumer accepts kw_out_data.
- kw_out_data  out  32  SubWord result.
- busy  out  1  state FSM not IDLE, or kw_out_valid high.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-job):
  - State FSM goes to S_IDLE; beat counter = 0; steal flag = 0.
  - st_out_valid, kw_out_valid, busy = 0; st_out_data and kw_out_data = 0.
  - Any in-flight job is discarded.
- State FSM states: S_IDLE, S_RUN, S_DONE.
  - S_IDLE: st_ready = 1. On accept, capture st_data into the working register, clear the beat counter, go to S_RUN. No lanes are used in the accept cycle.
  - S_RUN: st_ready = 0.
    - Beat k drives lane i with byte k*NUM_SBOX+i and writes the result back in place at the clock edge.
    - The counter advances only on non-stolen cycles.
    - When the last beat (k = BEATS-1) completes, go to S_DONE.
  - S_DONE: st_out_valid = 1; st_out_data is held stable. On st_out_ready, go to S_IDLE; st_out_valid drops the next cycle.
- State latency: st_out_valid rises BEATS cycles after the accept edge if no steal occurs. Each steal adds exactly 1 cycle.
- Key path (single-stage pipeline, no FSM):
  - kw_ready = (!kw_out_valid | kw_out_ready) & !steal_flag.
  - In the accept cycle, kw_data bytes 0..3 are driven combinationally into lanes 0..3.
  - The result is registered at the accept edge; kw_out_valid is high the next cycle, so latency is 1.
  - kw_out_valid/data are held until kw_out_ready.
  - A back-to-back accept with kw_out_ready high sustains one word per cycle when no steal is pending.
- Lane conflict:
  - A key accept during an S_RUN cycle owns lanes 0..3; that state beat stalls (counter holds, no write-back).
  - For NUM_SBOX > 4, the whole beat stalls; partial beats are never performed.
- Anti-starvation: a steal sets steal_flag for the following cycle only. That forces kw_ready = 0 and guarantees the state beat executes. The flag is never set by key accepts outside S_RUN.
- Simultaneous events:
  - Key accept and state accept in the same IDLE cycle: both accepted, no stall.
  - Key accept during S_DONE or S_IDLE: no stall.
- Independence: backpressure on either output never blocks the other path, except through lane stealing.

Test Plan:
1. NUM_SBOX=4: st_data=00112233445566778899aabbccddeeff, st_out_ready=1, no key traffic -> st_out_data=638293c31bfc33f5c4eeacea4bc12816. st_out_valid rises 4 cycles after the accept edge, lasts 1 cycle; st_ready returns high the next cycle.
2. Idle state FSM: kw_data=cf4f3c09 -> kw_out_data=8a84eb01, kw_out_valid high the cycle after accept. Words 00000000 then ffffffff back-to-back with kw_out_ready=1 -> 63636363 then 16161616 on consecutive cycles.
3. Same state as test 1, with kw_valid held high for 2 words starting in the beat-1 cycle:
   - Beat 1 stalls; kw_ready is low the following cycle, so beat 1 executes there.
   - The second word then steals beat 2.
   - -> st_out_data is unchanged from test 1, latency 6; both key results are correct.
4. st_out_ready held low 3 cycles after completion -> st_out_valid/data stable for 4 cycles, st_ready stays 0. A key word issued meanwhile completes in 1 cycle with no stall.
5. Assert rst asynchronously mid-beat 2 with kw_out_valid=1 -> all outputs 0 before the next clock edge. After release, st_ready=1; a fresh test-1 job returns the correct result.
6. NUM_SBOX=16: test-1 state -> result 1 cycle after accept. A key steal in the run cycle -> latency 2; the result is still correct.
